// File: rtl/lsu_align.sv
// Load/store alignment unit in front of a word-addressed RAM with a
// synchronous read-before-write port; sub-word stores are read-modify-write.
module lsu_align #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_0800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } state_t;

  localparam logic [2:0] F3_BYTE  = 3'b000;
  localparam logic [2:0] F3_HALF  = 3'b001;
  localparam logic [2:0] F3_WORD  = 3'b010;
  localparam logic [2:0] F3_BYTEU = 3'b100;
  localparam logic [2:0] F3_HALFU = 3'b101;

  state_t      state_q;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic        widthLegal;
  logic        alignLegal;
  logic        rangeLegal;
  logic        accessLegal;
  logic [31:0] rdata_d;
  logic [31:0] storeMerged;

  // Legality is judged straight from the ports so a bad request never
  // leaves IDLE and never touches the RAM.
  always_comb begin
    widthLegal = 1'b0;
    if (is_store) begin
      widthLegal = (funct3 == F3_BYTE) || (funct3 == F3_HALF) ||
                   (funct3 == F3_WORD);
    end else begin
      widthLegal = (funct3 == F3_BYTE)  || (funct3 == F3_HALF)  ||
                   (funct3 == F3_WORD)  || (funct3 == F3_BYTEU) ||
                   (funct3 == F3_HALFU);
    end
    alignLegal = 1'b1;
    if (funct3[1:0] == 2'b01) begin
      alignLegal = (addr[0] == 1'b0);
    end else if (funct3[1:0] == 2'b10) begin
      alignLegal = (addr[1:0] == 2'b00);
    end
    rangeLegal  = (addr < ADDR_LIMIT);
    accessLegal = widthLegal && alignLegal && rangeLegal;
  end

  // Lane extraction and extension of the word the RAM returns in LOAD.
  always_comb begin
    logic [31:0] shifted;
    logic [7:0]  byteLane;
    logic [15:0] halfLane;
    shifted  = mem_rdata >> {addr_q[1:0], 3'b000};
    byteLane = shifted[7:0];
    halfLane = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    rdata_d  = mem_rdata;
    unique case (funct3_q)
      F3_BYTE:  rdata_d = {{24{byteLane[7]}}, byteLane};
      F3_HALF:  rdata_d = {{16{halfLane[15]}}, halfLane};
      F3_BYTEU: rdata_d = {24'h000000, byteLane};
      F3_HALFU: rdata_d = {16'h0000, halfLane};
      default:  rdata_d = mem_rdata;
    endcase
  end

  // Merge the lane-shifted store data into the old word under a byte mask.
  always_comb begin
    logic [3:0]  byteMask;
    logic [31:0] bitMask;
    logic [31:0] shiftedData;
    shiftedData = wdata_q << {addr_q[1:0], 3'b000};
    unique case (funct3_q[1:0])
      2'b00:   byteMask = 4'b0001 << addr_q[1:0];
      2'b01:   byteMask = addr_q[1] ? 4'b1100 : 4'b0011;
      default: byteMask = 4'b1111;
    endcase
    bitMask = {{8{byteMask[3]}}, {8{byteMask[2]}},
               {8{byteMask[1]}}, {8{byteMask[0]}}};
    storeMerged = (shiftedData & bitMask) | (mem_rdata & ~bitMask);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= 32'h0;
      funct3_q <= 3'b000;
      wdata_q  <= 32'h0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            if (accessLegal) begin
              addr_q   <= addr;
              funct3_q <= funct3;
              wdata_q  <= wdata;
              state_q  <= is_store ? STORE : LOAD;
            end else begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end
          end
        end
        LOAD: begin
          rdata_q <= rdata_d;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        STORE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The RAM samples the port address at the accept edge, so IDLE passes it through.
  assign mem_addr  = (state_q == IDLE) ? {addr[31:2], 2'b00} : {addr_q[31:2], 2'b00};
  assign mem_we    = (state_q == STORE) && rst_n;
  assign mem_wdata = (state_q == STORE) ? storeMerged : 32'h0;
  assign ready     = (state_q == IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align with a behavioural read-before-write RAM.
module tb_lsu_align;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] ram [0:511];
  int checks = 0;
  int errors = 0;
  int weCount = 0;

  lsu_align dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .is_store  (is_store),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: registered read of the old word, write on the same edge.
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr[10:2]];
    if (mem_we) begin
      ram[mem_addr[10:2]] <= mem_wdata;
      weCount <= weCount + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic st, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd);
    req      = r;
    is_store = st;
    funct3   = f3;
    addr     = a;
    wdata    = wd;
  endtask

  // Starts and ends just after a falling edge; checks timing, flags and result.
  task automatic runAccess(input string tag, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic expErr, input logic [31:0] expRdata);
    int weBefore;
    weBefore = weCount;
    applyStimulus(1'b1, st, f3, a, wd);
    #1;
    checkOutput({tag, " ready"}, {31'h0, ready}, 32'd1);
    checkOutput({tag, " mem_addr"}, mem_addr, {a[31:2], 2'b00});
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    if (expErr) begin
      checkOutput({tag, " done"}, {31'h0, done}, 32'd1);
      checkOutput({tag, " err"}, {31'h0, err}, 32'd1);
      checkOutput({tag, " mem_we"}, {31'h0, mem_we}, 32'd0);
    end else begin
      checkOutput({tag, " early done"}, {31'h0, done}, 32'd0);
      checkOutput({tag, " mem_we"}, {31'h0, mem_we}, {31'h0, st});
      @(negedge clk);
      #1;
      checkOutput({tag, " done"}, {31'h0, done}, 32'd1);
      checkOutput({tag, " err"}, {31'h0, err}, 32'd0);
    end
    checkOutput({tag, " rdata"}, rdata, expRdata);
    checkOutput({tag, " we pulses"}, weCount - weBefore, (st && !expErr) ? 32'd1 : 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 32'h0;
    ram[4] = 32'h8899AABB;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset ready", {31'h0, ready}, 32'd1);
    checkOutput("reset done", {31'h0, done}, 32'd0);
    checkOutput("reset err", {31'h0, err}, 32'd0);
    checkOutput("reset rdata", rdata, 32'h0);
    checkOutput("reset mem_we", {31'h0, mem_we}, 32'd0);
    checkOutput("reset mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);

    $display("[TB] loads");
    runAccess("LW 0x10",  1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h8899AABB);
    runAccess("LB 0x13",  1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFFFF88);
    runAccess("LBU 0x13", 1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 32'h00000088);
    runAccess("LH 0x12",  1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'hFFFF8899);
    runAccess("LHU 0x10", 1'b0, 3'b101, 32'h10, 32'h0, 1'b0, 32'h0000AABB);
    runAccess("LB 0x10",  1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 32'hFFFFFFBB);

    $display("[TB] stores");
    runAccess("SB 0x11", 1'b1, 3'b000, 32'h11, 32'h12345677, 1'b0, 32'hFFFFFFBB);
    checkOutput("ram after SB", ram[4], 32'h889977BB);
    runAccess("SH 0x12", 1'b1, 3'b001, 32'h12, 32'h0000CAFE, 1'b0, 32'hFFFFFFBB);
    checkOutput("ram after SH", ram[4], 32'hCAFE77BB);
    runAccess("SW 0x10", 1'b1, 3'b010, 32'h10, 32'h01020304, 1'b0, 32'hFFFFFFBB);
    checkOutput("ram after SW", ram[4], 32'h01020304);

    $display("[TB] illegal accesses");
    runAccess("LW 0x12 misaligned",  1'b0, 3'b010, 32'h12,  32'h0, 1'b1, 32'hFFFFFFBB);
    runAccess("SH 0x11 misaligned",  1'b1, 3'b001, 32'h11,  32'hFFFF, 1'b1, 32'hFFFFFFBB);
    runAccess("LB 0x800 range",      1'b0, 3'b000, 32'h800, 32'h0, 1'b1, 32'hFFFFFFBB);
    runAccess("load funct3 011",     1'b0, 3'b011, 32'h10,  32'h0, 1'b1, 32'hFFFFFFBB);
    runAccess("store funct3 100",    1'b1, 3'b100, 32'h10,  32'h55, 1'b1, 32'hFFFFFFBB);
    checkOutput("ram after illegal", ram[4], 32'h01020304);
    runAccess("LW 0x7FC last word",  1'b0, 3'b010, 32'h7FC, 32'h0, 1'b0, 32'h00000000);

    $display("[TB] back-to-back");
    applyStimulus(1'b1, 1'b1, 3'b000, 32'h10, 32'h000000AA);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    checkOutput("b2b SB done", {31'h0, done}, 32'd1);
    checkOutput("b2b ready in done", {31'h0, ready}, 32'd1);
    runAccess("b2b LW 0x10", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h010203AA);

    $display("[TB] reset during store");
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst mem_we gated", {31'h0, mem_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst ready", {31'h0, ready}, 32'd1);
    checkOutput("rst done", {31'h0, done}, 32'd0);
    checkOutput("rst err", {31'h0, err}, 32'd0);
    checkOutput("rst rdata cleared", rdata, 32'h0);
    checkOutput("rst ram kept", ram[4], 32'h010203AA);
    @(negedge clk);
    runAccess("LW after reset", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h010203AA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
